rx_hex_word: RTL

RX_HEX_WORD -- requirements
Module: rx_hex_word

---
 rtl/rx_hex_word_pkg.sv | 27 ++
 rtl/rx_hex_word_if.sv | 17 +
 rtl/uart_rx.sv | 109 ++++++++++
 rtl/rx_hex_word.sv | 132 +++++++++++++
 4 files changed

// File: rtl/rx_hex_word_pkg.sv
// rtl/rx_hex_word_pkg.sv - ASCII constants and state encodings shared by the hex word receiver and transmitter
// Purpose: one place for the framing characters and the FSM encodings of
//          both the byte receiver and the word assembler.
package rx_hex_word_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0d;
    localparam logic [7:0] ASCII_LF = 8'h0a;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;

    // Word assembler states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DISCARD = 2'd2
    } asm_state_t;

    // UART byte receiver states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/rx_hex_word_if.sv
// rtl/rx_hex_word_if.sv - serial line, enable and word result bundle of the hex word receiver
// Purpose: groups the receiver's line side and result side.
// Signals: RX (serial line, idle high), enable, rx_data (last word),
//          valid (word pulse), error (rejection pulse).
// Modports: master drives the line and enable; slave is the receiver.
interface rx_hex_word_if #(
    parameter int RESOLUTION = 32
) ();
    logic                  RX;
    logic                  enable;
    logic [RESOLUTION-1:0] rx_data;
    logic                  valid;
    logic                  error;

    modport master (output RX, output enable, input rx_data, input valid, input error);
    modport slave  (input RX, input enable, output rx_data, output valid, output error);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART byte receiver, counterpart of uart_tx
// Purpose: recovers bytes from an idle-high, LSB-first serial line with
//          2^SHIFT clk cycles per bit.
// Ports: clk, reset (async, active high), rx_i (serial line), enable_i
//        (low holds the receiver idle), data_o (received byte), strobe_o
//        (one-cycle byte strobe), ferr_o (stop bit was low, valid with strobe).
module uart_rx
    import rx_hex_word_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    input  logic       enable_i,
    output logic [7:0] data_o,
    output logic       strobe_o,
    output logic       ferr_o
);
    localparam logic [SHIFT-1:0] CNT_HALF = SHIFT'(2 ** (SHIFT - 1) - 1);
    localparam logic [SHIFT-1:0] CNT_FULL = SHIFT'(2 ** SHIFT - 1);

    logic sync1_q, sync2_q, prev_q;
    uart_state_t state_q, state_d;
    logic [SHIFT-1:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic strobe_q, strobe_d;
    logic ferr_q, ferr_d;

    // Synchroniser plus one history flop for falling-edge detection; all
    // preset high so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RX_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            strobe_q <= strobe_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + SHIFT'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        strobe_d = 1'b0;
        ferr_d   = ferr_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) state_d = RX_START;
            end
            RX_START: begin
                // Half a bit after the edge: a high line means a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    strobe_d = 1'b1;
                    ferr_d   = !sync2_q;
                    state_d  = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
        if (!enable_i) begin
            state_d  = RX_IDLE;
            cnt_d    = '0;
            strobe_d = 1'b0;
        end
    end

    assign data_o   = shift_q;
    assign strobe_o = strobe_q;
    assign ferr_o   = ferr_q;
endmodule

// File: rtl/rx_hex_word.sv
// rtl/rx_hex_word.sv - receives CR-terminated ASCII hex words over a UART line
// Purpose: decodes TOTAL_NIBBLES hex digits (MSB first) followed by CR into
//          a RESOLUTION-bit word; LF is ignored everywhere.
// Ports: clk, reset (async, active high), bus (slave modport: RX, enable in;
//        rx_data, valid, error out).
module rx_hex_word
    import rx_hex_word_pkg::*;
#(
    parameter int SHIFT         = 4,
    parameter int RESOLUTION    = 32,
    parameter int TOTAL_NIBBLES = RESOLUTION / 4
) (
    input logic           clk,
    input logic           reset,
    rx_hex_word_if.slave  bus
);
    localparam int CW = $clog2(TOTAL_NIBBLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TOTAL_NIBBLES);

    logic [7:0] rx_byte;
    logic rx_strobe, rx_ferr;
    logic [4:0] dec;

    asm_state_t state_q, state_d;
    logic [RESOLUTION-1:0] shreg_q, shreg_d;
    logic [RESOLUTION-1:0] rx_data_q, rx_data_d;
    logic [CW-1:0] count_q, count_d;
    logic valid_q, valid_d;
    logic error_q, error_d;

    uart_rx #(.SHIFT(SHIFT)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rx_i     (bus.RX),
        .enable_i (bus.enable),
        .data_o   (rx_byte),
        .strobe_o (rx_strobe),
        .ferr_o   (rx_ferr)
    );

    // Returns {is_hex, nibble}
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        if (c >= ASCII_0 && c <= ASCII_0 + 8'd9)
            return {1'b1, 4'(c - ASCII_0)};
        else if (c >= ASCII_UA && c <= ASCII_UA + 8'd5)
            return {1'b1, 4'(c - ASCII_UA + 8'd10)};
        else if (c >= ASCII_LA && c <= ASCII_LA + 8'd5)
            return {1'b1, 4'(c - ASCII_LA + 8'd10)};
        else
            return 5'd0;
    endfunction

    assign dec = hex_decode(rx_byte);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            rx_data_q <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            rx_data_q <= rx_data_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        rx_data_d = rx_data_q;
        count_d   = count_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            count_d = '0;
        end else if (rx_strobe) begin
            if (rx_ferr) begin
                error_d = 1'b1;
                state_d = DISCARD;
                count_d = '0;
            end else if (rx_byte != ASCII_LF) begin
                case (state_q)
                    IDLE: begin
                        if (dec[4]) begin
                            shreg_d = RESOLUTION'(dec[3:0]);
                            count_d = CW'(1);
                            state_d = COLLECT;
                        end else if (rx_byte != ASCII_CR) begin
                            error_d = 1'b1;
                            state_d = DISCARD;
                        end
                    end
                    COLLECT: begin
                        if (dec[4] && count_q < CNT_MAX) begin
                            shreg_d = (shreg_q << 4) | RESOLUTION'(dec[3:0]);
                            count_d = count_q + CW'(1);
                        end else if (rx_byte == ASCII_CR) begin
                            // Short word: reported, but the held word stays.
                            if (count_q == CNT_MAX) begin
                                rx_data_d = shreg_q;
                                valid_d   = 1'b1;
                            end else begin
                                error_d = 1'b1;
                            end
                            state_d = IDLE;
                            count_d = '0;
                        end else begin
                            error_d = 1'b1;
                            state_d = DISCARD;
                            count_d = '0;
                        end
                    end
                    DISCARD: begin
                        if (rx_byte == ASCII_CR) state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign bus.rx_data = rx_data_q;
    assign bus.valid   = valid_q;
    assign bus.error   = error_q;
endmodule
